// File: rtl/cla_pipe.sv
// cla_pipe: pipelined carry-lookahead add/subtract, one WIDTH/STAGES-bit segment per stage.
// Define CLA_FLAGS_EN to add the out_cout/out_ovf ports and the final-stage carry register.
module cla_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum
`ifdef CLA_FLAGS_EN
    ,
    output logic             out_cout,
    output logic             out_ovf
`endif
);
    localparam int NS  = (STAGES < 1) ? 1 : STAGES;
    localparam int SEG = WIDTH / NS;
    localparam int NG  = SEG / 4;
    localparam int NC  = (NS > 1) ? NS - 1 : 1;

    if (STAGES < 1) begin : g_bad_stages
        $error("cla_pipe: STAGES must be >= 1");
    end else if (WIDTH % (4 * STAGES) != 0) begin : g_bad_width
        $error("cla_pipe: WIDTH must be a multiple of 4*STAGES");
    end

    // r_x[k]: sum bits of segments 0..k in place, operand A bits above them still unconsumed
    logic [WIDTH-1:0] r_x [NS];
    logic [WIDTH-1:0] r_b [NS];
    logic [NS-1:0]    r_v;
    logic [NC-1:0]    r_c;
    logic [WIDTH-1:0] w_x [NS];
    logic [WIDTH-1:0] w_b [NS];
    logic [WIDTH-1:0] w_nx [NS];
    logic             w_co [NS];
    logic             w_adv;
`ifdef CLA_FLAGS_EN
    logic             w_cmsb;
    logic             r_cout;
    logic             r_ovf;
`endif

    // returns {group G, group P, c3, c2, c1, c0} for one 4-bit lookahead group
    function automatic logic [5:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic c0);
        logic c1, c2, c3;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]),
                &p, c3, c2, c1, c0};
    endfunction

    always_comb begin
        logic [3:0] g4, p4;
        logic [5:0] t;
        logic       cg;
        g4 = '0;
        p4 = '0;
        t  = '0;
        cg = 1'b0;
        for (int k = 0; k < NS; k++) begin
            w_x[k]  = (k == 0) ? in_a : r_x[(k == 0) ? 0 : k - 1];
            w_b[k]  = (k == 0) ? (in_sub ? ~in_b : in_b) : r_b[(k == 0) ? 0 : k - 1];
            cg      = (k == 0) ? (in_sub | in_cin) : r_c[(k == 0) ? 0 : k - 1];
            w_nx[k] = w_x[k];
            for (int j = 0; j < NG; j++) begin
                g4 = w_x[k][k*SEG+4*j +: 4] & w_b[k][k*SEG+4*j +: 4];
                p4 = w_x[k][k*SEG+4*j +: 4] ^ w_b[k][k*SEG+4*j +: 4];
                t  = cla4(g4, p4, cg);
                w_nx[k][k*SEG+4*j +: 4] = p4 ^ t[3:0];
                cg = t[5] | (t[4] & cg);
            end
            w_co[k] = cg;
        end
`ifdef CLA_FLAGS_EN
        w_cmsb = t[3];
`endif
    end

    assign w_adv     = ~r_v[NS-1] | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v[NS-1];
    assign out_sum   = r_x[NS-1];
`ifdef CLA_FLAGS_EN
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
            r_c <= '0;
            for (int k = 0; k < NS; k++) begin
                r_x[k] <= '0;
                r_b[k] <= '0;
            end
`ifdef CLA_FLAGS_EN
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
`endif
        end else if (w_adv) begin
            for (int k = 0; k < NS; k++) begin
                r_v[k] <= (k == 0) ? in_valid : r_v[(k == 0) ? 0 : k - 1];
                r_x[k] <= w_nx[k];
                r_b[k] <= w_b[k];
            end
            for (int k = 0; k < NS - 1; k++) r_c[k] <= w_co[k];
`ifdef CLA_FLAGS_EN
            r_cout <= w_co[NS-1];
            r_ovf  <= w_cmsb ^ w_co[NS-1];
`endif
        end
    end
endmodule

// File: tb/tb_cla_pipe.sv
// tb_cla_pipe: directed checks of cla_pipe at STAGES=2/WIDTH=32, plus STAGES=1 and STAGES=4/WIDTH=64 instances.
module tb_cla_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_cin, in_sub, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_sum;
    logic        c_valid, c_cin, c_sub, c_rdy;
    logic [63:0] c_a, c_b;
    logic        o1_valid, o1_rdy, o4_valid, o4_rdy;
    logic [31:0] o1_sum;
    logic [63:0] o4_sum;
`ifdef CLA_FLAGS_EN
    logic        out_cout, out_ovf, o1_cout, o1_ovf, o4_cout, o4_ovf;
`endif
    int n_run = 0;
    int n_fail = 0;

    localparam logic [63:0] CA [5] = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                                       64'h0123_4567_89AB_CDEF, 64'h0000_0001_0000_0000};
    localparam logic [63:0] CB [5] = '{64'h1, 64'h0, 64'h1, 64'h1111_1111_1111_1111, 64'h1};
    localparam logic        CC [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic        CS [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic [63:0] CE64 [5] = '{64'h0000_0001_0000_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
                                         64'h1234_5678_9ABC_DF00, 64'h0000_0000_FFFF_FFFF};
    localparam logic [31:0] CE32 [5] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h9ABC_DF00, 32'hFFFF_FFFF};

    localparam logic [31:0] DA [6] = '{32'h0000_FFFF, 32'hFFFF_FFFF, 32'h1234_5678,
                                       32'h0001_0000, 32'h8000_0000, 32'h0000_FFFF};
    localparam logic [31:0] DB [6] = '{32'h1, 32'h0, 32'h9ABC_DEF0, 32'h1, 32'h1, 32'h0000_FFFF};
    localparam logic        DC [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic        DS [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [31:0] DE [6] = '{32'h0001_0000, 32'h0, 32'hACF1_3568,
                                       32'h0000_FFFF, 32'h7FFF_FFFF, 32'h0001_FFFF};

    always #5 clk = ~clk;

    cla_pipe #(.WIDTH(32), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_cin(in_cin), .in_sub(in_sub), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
`ifdef CLA_FLAGS_EN
        , .out_cout(out_cout), .out_ovf(out_ovf)
`endif
    );

    cla_pipe #(.WIDTH(32), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(o1_rdy), .in_a(c_a[31:0]), .in_b(c_b[31:0]),
        .in_cin(c_cin), .in_sub(c_sub), .out_valid(o1_valid), .out_ready(c_rdy), .out_sum(o1_sum)
`ifdef CLA_FLAGS_EN
        , .out_cout(o1_cout), .out_ovf(o1_ovf)
`endif
    );

    cla_pipe #(.WIDTH(64), .STAGES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(o4_rdy), .in_a(c_a), .in_b(c_b),
        .in_cin(c_cin), .in_sub(c_sub), .out_valid(o4_valid), .out_ready(c_rdy), .out_sum(o4_sum)
`ifdef CLA_FLAGS_EN
        , .out_cout(o4_cout), .out_ovf(o4_ovf)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_sub = sub;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_run++; if (out_sum !== 32'h0) begin n_fail++; $display("FAIL reset_sum: got %h want 0", out_sum); end
        n_run++; if (o1_valid !== 1'b0 || o4_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_valid: got %b%b want 00", o1_valid, o4_valid); end
        rst = 1'b0;
        #1;
        n_run++; if ({in_ready, o1_rdy, o4_rdy} !== 3'b111) begin n_fail++; $display("FAIL reset_ready: got %b want 111", {in_ready, o1_rdy, o4_rdy}); end
    endtask

    task automatic test_add_wrap();
        drive(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_early: got %b want 0", out_valid); end
        step();
        n_run++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid: got %b want 1", out_valid); end
        n_run++; if (out_sum !== 32'h0) begin n_fail++; $display("FAIL wrap_sum: got %h want 00000000", out_sum); end
`ifdef CLA_FLAGS_EN
        n_run++; if ({out_cout, out_ovf} !== 2'b10) begin n_fail++; $display("FAIL wrap_flags: got %b want 10", {out_cout, out_ovf}); end
`endif
        step();
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_dup: got %b want 0", out_valid); end
    endtask

    task automatic test_sub_ovf();
        drive(32'h5, 32'h7, 1'b1, 1'b1);
        step();
        drive(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        n_run++; if (out_valid !== 1'b1 || out_sum !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_sum: got %b/%h want 1/fffffffe", out_valid, out_sum); end
`ifdef CLA_FLAGS_EN
        n_run++; if ({out_cout, out_ovf} !== 2'b00) begin n_fail++; $display("FAIL sub_flags: got %b want 00", {out_cout, out_ovf}); end
`endif
        step();
        n_run++; if (out_valid !== 1'b1 || out_sum !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_sum: got %b/%h want 1/80000000", out_valid, out_sum); end
`ifdef CLA_FLAGS_EN
        n_run++; if ({out_cout, out_ovf} !== 2'b01) begin n_fail++; $display("FAIL ovf_flags: got %b want 01", {out_cout, out_ovf}); end
`endif
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] expq[$];
        logic [31:0] a, b, e;
        logic        cin, sub;
        int          bad = 0;
        for (int i = 0; i <= 1000; i++) begin
            if (i < 6) begin
                drive(DA[i], DB[i], DC[i], DS[i]);
                expq.push_back(DE[i]);
            end else if (i < 1000) begin
                a = $urandom;
                b = $urandom;
                if (i % 7 == 0) begin a = 32'h0000_FFFF; b = 32'h1; end
                cin = 1'($urandom_range(0, 1));
                sub = 1'($urandom_range(0, 1));
                drive(a, b, cin, sub);
                e = a + (sub ? ~b : b) + {31'b0, sub | cin};
                expq.push_back(e);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 1) begin
                e = expq.pop_front();
                n_run++;
                if (out_valid !== 1'b1 || out_sum !== e) begin
                    n_fail++;
                    if (bad++ < 10) $display("FAIL b2b_%0d: got %b/%h want 1/%h", i - 1, out_valid, out_sum, e);
                end
            end
        end
        step();
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        drive(32'h1, 32'h2, 1'b0, 1'b0);
        step();
        drive(32'h0000_FFFF, 32'h1, 1'b0, 1'b0);
        step();
        n_run++; if (out_valid !== 1'b1 || out_sum !== 32'h3) begin n_fail++; $display("FAIL stall_fill: got %b/%h want 1/00000003", out_valid, out_sum); end
        out_ready = 1'b0;
        drive(32'h10, 32'h1, 1'b0, 1'b1);
        #1;
        n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready0: got %b want 0", in_ready); end
        for (int i = 0; i < 5; i++) begin
            step();
            n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_%0d: got %b want 0", i, in_ready); end
            n_run++; if (out_valid !== 1'b1 || out_sum !== 32'h3) begin n_fail++; $display("FAIL stall_hold_%0d: got %b/%h want 1/00000003", i, out_valid, out_sum); end
`ifdef CLA_FLAGS_EN
            n_run++; if ({out_cout, out_ovf} !== 2'b00) begin n_fail++; $display("FAIL stall_flags_%0d: got %b want 00", i, {out_cout, out_ovf}); end
`endif
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_run++; if (out_valid !== 1'b1 || out_sum !== 32'h0001_0000) begin n_fail++; $display("FAIL stall_rel_b: got %b/%h want 1/00010000", out_valid, out_sum); end
        step();
        n_run++; if (out_valid !== 1'b1 || out_sum !== 32'hF) begin n_fail++; $display("FAIL stall_rel_c: got %b/%h want 1/0000000f", out_valid, out_sum); end
        step();
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_once: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midflight();
        drive(32'h11, 32'h22, 1'b0, 1'b0);
        step();
        drive(32'h33, 32'h44, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        n_run++; if (out_sum !== 32'h0) begin n_fail++; $display("FAIL midrst_sum: got %h want 0", out_sum); end
        step();
        rst = 1'b0;
        #1;
        n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale_%0d: got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_configs();
        for (int i = 0; i < 8; i++) begin
            if (i < 5) begin
                c_valid = 1'b1;
                c_a = CA[i];
                c_b = CB[i];
                c_cin = CC[i];
                c_sub = CS[i];
            end else begin
                c_valid = 1'b0;
            end
            step();
            if (i < 5) begin
                n_run++; if (o1_valid !== 1'b1 || o1_sum !== CE32[i]) begin n_fail++; $display("FAIL s1_%0d: got %b/%h want 1/%h", i, o1_valid, o1_sum, CE32[i]); end
            end else begin
                n_run++; if (o1_valid !== 1'b0) begin n_fail++; $display("FAIL s1_drain_%0d: got %b want 0", i, o1_valid); end
            end
            if (i >= 3) begin
                n_run++; if (o4_valid !== 1'b1 || o4_sum !== CE64[i-3]) begin n_fail++; $display("FAIL s4_%0d: got %b/%h want 1/%h", i - 3, o4_valid, o4_sum, CE64[i-3]); end
            end else begin
                n_run++; if (o4_valid !== 1'b0) begin n_fail++; $display("FAIL s4_lat_%0d: got %b want 0", i, o4_valid); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_cin = 1'b0;
        in_sub = 1'b0;
        out_ready = 1'b1;
        c_valid = 1'b0;
        c_a = '0;
        c_b = '0;
        c_cin = 1'b0;
        c_sub = 1'b0;
        c_rdy = 1'b1;
        test_reset();
        test_add_wrap();
        test_sub_ovf();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_configs();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
